// File: rtl/stdcell_exhaustive_tester.sv
// stdcell_exhaustive_tester: walks all 2^n input vectors into a standard-cell array and
// checks one selected cell output against a truth table, reporting mismatches.
module stdcell_exhaustive_tester #(
    parameter int N_CELLS       = 20,
    parameter int MAX_IN        = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 5,
    localparam int SEL_W        = (N_CELLS > 1) ? $clog2(N_CELLS) : 1,
    localparam int TBL_W        = 2 ** MAX_IN,
    localparam int CW           = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [SEL_W-1:0]   cell_sel_i,
    input  logic [2:0]         n_inputs_i,
    input  logic [TBL_W-1:0]   truth_tbl_i,
    input  logic [N_CELLS-1:0] cell_y_i,
    output logic [MAX_IN-1:0]  stim_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               cfg_err_o,
    output logic [CNT_W-1:0]   err_count_o,
    output logic               fail_vld_o,
    output logic [MAX_IN-1:0]  fail_vec_o
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    state_e             state_q, state_d;
    logic [MAX_IN-1:0]  vec_q, vec_d, fail_vec_q, fail_vec_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [2:0]         n_q, n_d;
    logic [TBL_W-1:0]   tbl_q, tbl_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d, cfg_err_q, cfg_err_d, fail_vld_q, fail_vld_d;
    logic               cfg_ok, last_vec, y_sel, mismatch;

    assign cfg_ok   = (n_inputs_i != 3'd0) && ({29'd0, n_inputs_i} <= 32'(MAX_IN));
    assign last_vec = ({1'b0, vec_q} + 1'b1) == ((MAX_IN+1)'(1) << n_q);
    // Out-of-range selects read a constant 0 rather than an undefined bit.
    assign y_sel    = ({1'b0, sel_q} < (SEL_W+1)'(N_CELLS)) ? cell_y_i[sel_q] : 1'b0;
    assign mismatch = y_sel != tbl_q[vec_q];

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        n_d        = n_q;
        tbl_d      = tbl_q;
        err_d      = err_q;
        pass_d     = pass_q;
        cfg_err_d  = cfg_err_q;
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
        case (state_q)
            IDLE: if (start_i) begin
                sel_d      = cell_sel_i;
                n_d        = n_inputs_i;
                tbl_d      = truth_tbl_i;
                err_d      = '0;
                pass_d     = 1'b0;
                fail_vld_d = 1'b0;
                fail_vec_d = '0;
                vec_d      = '0;
                cnt_d      = '0;
                cfg_err_d  = !cfg_ok;
                state_d    = cfg_ok ? SETTLE : DONE;
            end
            SETTLE: begin
                if (abort_i) begin
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (abort_i) begin
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (mismatch) begin
                        err_d      = &err_q ? err_q : err_q + 1'b1;
                        fail_vld_d = 1'b1;
                        fail_vec_d = fail_vld_q ? fail_vec_q : vec_q;
                    end
                    vec_d   = last_vec ? vec_q : vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = last_vec ? DONE : SETTLE;
                end
            end
            default: begin
                pass_d  = (err_q == '0) && !cfg_err_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            n_q        <= '0;
            tbl_q      <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            n_q        <= n_d;
            tbl_q      <= tbl_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
            cfg_err_q  <= cfg_err_d;
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign stim_o      = (state_q == SETTLE || state_q == SAMPLE) ? vec_q : '0;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign pass_o      = pass_q;
    assign cfg_err_o   = cfg_err_q;
    assign err_count_o = err_q;
    assign fail_vld_o  = fail_vld_q;
    assign fail_vec_o  = fail_vec_q;
endmodule

// File: tb/tb_stdcell_exhaustive_tester.sv
// tb_stdcell_exhaustive_tester: directed vectors against behavioural cell models; a second
// instance with a 3-bit error counter exercises saturation on the same stimulus.
module tb_stdcell_exhaustive_tester;
    logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic [4:0]  cell_sel_i = '0;
    logic [2:0]  n_inputs_i = '0;
    logic [15:0] truth_tbl_i = '0;
    logic [19:0] cell_y_i;
    logic [3:0]  stim_o, fail_vec_o, stim2_o, fail_vec2_o;
    logic        busy_o, done_o, pass_o, cfg_err_o, fail_vld_o;
    logic        busy2_o, done2_o, pass2_o, cfg_err2_o, fail_vld2_o;
    logic [4:0]  err_count_o;
    logic [2:0]  err_count2_o;

    stdcell_exhaustive_tester dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .cell_sel_i(cell_sel_i), .n_inputs_i(n_inputs_i), .truth_tbl_i(truth_tbl_i),
        .cell_y_i(cell_y_i), .stim_o(stim_o), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .cfg_err_o(cfg_err_o), .err_count_o(err_count_o),
        .fail_vld_o(fail_vld_o), .fail_vec_o(fail_vec_o));

    stdcell_exhaustive_tester #(.CNT_W(3)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .cell_sel_i(cell_sel_i), .n_inputs_i(n_inputs_i), .truth_tbl_i(truth_tbl_i),
        .cell_y_i(cell_y_i), .stim_o(stim2_o), .busy_o(busy2_o), .done_o(done2_o),
        .pass_o(pass2_o), .cfg_err_o(cfg_err2_o), .err_count_o(err_count2_o),
        .fail_vld_o(fail_vld2_o), .fail_vec_o(fail_vec2_o));

    always #5 clk_i = ~clk_i;

    // ch3 AND2, ch5 XOR2 stuck-at-0, ch7 AOI22, ch9 INV wired as a buffer; rest tied high
    always_comb begin
        cell_y_i    = '1;
        cell_y_i[3] = stim_o[0] & stim_o[1];
        cell_y_i[5] = 1'b0;
        cell_y_i[7] = ~((stim_o[0] & stim_o[1]) | (stim_o[2] & stim_o[3]));
        cell_y_i[9] = stim_o[0];
    end

    typedef struct {
        logic [4:0]  sel;
        logic [2:0]  n;
        logic [15:0] tbl;
        int err, pass, fvld, fvec, cfg;
    } vec_t;

    vec_t tv[10];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input logic [4:0] sel, input logic [2:0] n, input logic [15:0] tbl,
                       input int glitch, input bit abort_done);
        int cyc, bad, lat;
        lat = (n != 0 && n <= 4) ? (1 << n) * 5 + 1 : 1;
        cell_sel_i = sel; n_inputs_i = n; truth_tbl_i = tbl; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 1; bad = 0;
        while (!done_o && cyc < 200) begin
            if (!busy_o || stim_o !== 4'((cyc - 1) / 5)) bad++;
            if (cyc == glitch) begin
                start_i = 1'b1; n_inputs_i = 3'd4; truth_tbl_i = 16'h0; cell_sel_i = 5'd0;
            end else start_i = 1'b0;
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        chk("latency", cyc, lat);
        chk("stim_seq", bad, 0);
        chk("done_stim", int'(stim_o), 0);
        abort_i = abort_done;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("busy_after", int'(busy_o), 0);
        chk("done_once", int'(done_o), 0);
    endtask

    task automatic abort_run(input logic [4:0] sel, input logic [2:0] n, input logic [15:0] tbl,
                             input int at_vec, input int extra,
                             input int e_err, input int e_fvld, input int e_fvec);
        int k, dn;
        cell_sel_i = sel; n_inputs_i = n; truth_tbl_i = tbl; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        k = 0;
        while (int'(stim_o) != at_vec && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        chk("abort_reach", int'(stim_o), at_vec);
        repeat (extra) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_stim", int'(stim_o), 0);
        chk("abort_done", int'(done_o), 0);
        chk("abort_pass", int'(pass_o), 0);
        chk("abort_err", int'(err_count_o), e_err);
        chk("abort_fvld", int'(fail_vld_o), e_fvld);
        chk("abort_fvec", int'(fail_vec_o), e_fvec);
        dn = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (done_o || busy_o) dn++;
        end
        chk("abort_quiet", dn, 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, int'(busy_o), 0);
        chk({name, "_done"}, int'(done_o), 0);
        chk({name, "_stim"}, int'(stim_o), 0);
        chk({name, "_pass"}, int'(pass_o), 0);
        chk({name, "_cfg"}, int'(cfg_err_o), 0);
        chk({name, "_err"}, int'(err_count_o), 0);
        chk({name, "_fvld"}, int'(fail_vld_o), 0);
        chk({name, "_fvec"}, int'(fail_vec_o), 0);
    endtask

    initial begin
        int k, dn;
        tv[0] = '{5'd3,  3'd2, 16'h0008, 0,  1, 0, 0, 0};
        tv[1] = '{5'd5,  3'd2, 16'h0006, 2,  0, 1, 1, 0};
        tv[2] = '{5'd3,  3'd0, 16'h0008, 0,  0, 0, 0, 1};
        tv[3] = '{5'd3,  3'd5, 16'h0008, 0,  0, 0, 0, 1};
        tv[4] = '{5'd7,  3'd4, 16'h0777, 0,  1, 0, 0, 0};
        tv[5] = '{5'd25, 3'd3, 16'h0000, 0,  1, 0, 0, 0};
        tv[6] = '{5'd25, 3'd1, 16'h0002, 1,  0, 1, 1, 0};
        tv[7] = '{5'd9,  3'd4, 16'h5555, 16, 0, 1, 0, 0};
        tv[8] = '{5'd3,  3'd1, 16'h0000, 0,  1, 0, 0, 0};
        tv[9] = '{5'd3,  3'd7, 16'h0008, 0,  0, 0, 0, 1};

        repeat (2) @(negedge clk_i);
        chk_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 10; i++) begin
            run(tv[i].sel, tv[i].n, tv[i].tbl, 0, i == 0);
            chk($sformatf("v%0d_err", i), int'(err_count_o), tv[i].err);
            chk($sformatf("v%0d_err_sat", i), int'(err_count2_o), tv[i].err > 7 ? 7 : tv[i].err);
            chk($sformatf("v%0d_pass", i), int'(pass_o), tv[i].pass);
            chk($sformatf("v%0d_fvld", i), int'(fail_vld_o), tv[i].fvld);
            chk($sformatf("v%0d_fvec", i), int'(fail_vec_o), tv[i].fvec);
            chk($sformatf("v%0d_fvec_sat", i), int'(fail_vec2_o), tv[i].fvec);
            chk($sformatf("v%0d_cfg", i), int'(cfg_err_o), tv[i].cfg);
        end

        abort_run(5'd7, 3'd4, 16'h0777, 7, 0, 0, 0, 0);
        run(5'd7, 3'd4, 16'h0777, 0, 1'b0);
        chk("rerun_pass", int'(pass_o), 1);
        abort_run(5'd5, 3'd2, 16'h0006, 2, 0, 1, 1, 1);
        abort_run(5'd5, 3'd2, 16'h0006, 1, 4, 0, 0, 0);

        run(5'd3, 3'd2, 16'h0008, 3, 1'b0);
        chk("ignore_start_pass", int'(pass_o), 1);
        chk("ignore_start_err", int'(err_count_o), 0);

        cell_sel_i = 5'd5; n_inputs_i = 3'd2; truth_tbl_i = 16'h0006; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        k = 0;
        while (stim_o != 4'd2 && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        chk("pre_rst_err", int'(err_count_o), 1);
        #2 rst_ni = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        dn = 0;
        repeat (25) begin
            @(negedge clk_i);
            if (done_o || busy_o) dn++;
        end
        chk("rst_quiet", dn, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
